// File: rtl/clock_divider_pkg.sv
// rtl/clock_divider_pkg.sv - shared types, constants and helpers for the multi-channel clock divider
package clock_divider_pkg;

    localparam int MIN_PERIOD = 2;

    // Configuration values are widened to this before validation so one helper serves any WIDTH.
    localparam int CFG_MAX_W = 64;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic logic cfg_is_valid(
        input logic [CFG_MAX_W-1:0] period,
        input logic [CFG_MAX_W-1:0] high
    );
        return (period >= CFG_MAX_W'(MIN_PERIOD)) && (high != '0) && (high < period);
    endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// rtl/clock_divider_ch.sv - one divider channel: counter, active/pending config and output flops
module clock_divider_ch
    import clock_divider_pkg::*;
#(
    parameter int WIDTH          = 26,
    parameter int DEFAULT_PERIOD = 50000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             pending,
    output logic             new_clock,
    output logic             tick
);

    localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] RST_HIGH   = WIDTH'(DEFAULT_PERIOD / 2);

    ch_state_t        state;
    ch_state_t        state_nxt;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] act_p;
    logic [WIDTH-1:0] act_h;
    logic [WIDTH-1:0] act_p_nxt;
    logic [WIDTH-1:0] act_h_nxt;
    logic [WIDTH-1:0] pend_p;
    logic [WIDTH-1:0] pend_h;
    logic             pending_nxt;
    logic             new_clock_nxt;
    logic             tick_nxt;
    logic             wrap;
    logic             apply;

    // Outputs are registered from the next-cycle count so they line up with the count they describe.
    always_comb begin
        state_nxt     = CH_IDLE;
        count_nxt     = '0;
        tick_nxt      = 1'b0;
        new_clock_nxt = 1'b0;

        wrap  = (state == CH_RUN) && (count == act_p - WIDTH'(1));
        // An idle channel has no period in flight, so a pending value can land immediately.
        apply = pending && ((state == CH_IDLE) || (enable && wrap));

        act_p_nxt = apply ? pend_p : act_p;
        act_h_nxt = apply ? pend_h : act_h;

        if (enable) begin
            state_nxt = CH_RUN;
            if ((state == CH_IDLE) || wrap) begin
                count_nxt = '0;
                tick_nxt  = 1'b1;
            end else begin
                count_nxt = count + WIDTH'(1);
            end
            new_clock_nxt = (count_nxt >= (act_p_nxt - act_h_nxt));
        end

        pending_nxt = load | (pending & ~apply);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= CH_IDLE;
            count     <= '0;
            act_p     <= RST_PERIOD;
            act_h     <= RST_HIGH;
            pend_p    <= RST_PERIOD;
            pend_h    <= RST_HIGH;
            pending   <= 1'b0;
            new_clock <= 1'b0;
            tick      <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            act_p     <= act_p_nxt;
            act_h     <= act_h_nxt;
            pending   <= pending_nxt;
            new_clock <= new_clock_nxt;
            tick      <= tick_nxt;
            if (load) begin
                pend_p <= cfg_period;
                pend_h <= cfg_high;
            end
        end
    end

endmodule

// File: rtl/clock_divider_mc.sv
// rtl/clock_divider_mc.sv - multi-channel programmable clock/tick generator top
module clock_divider_mc
    import clock_divider_pkg::*;
#(
    parameter int  NUM_CH         = 4,
    parameter int  WIDTH          = 26,
    parameter int  DEFAULT_PERIOD = 50000000,
    localparam int CH_W           = ch_width(NUM_CH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_period,
    input  logic [WIDTH-1:0]  cfg_high,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] new_clock,
    output logic [NUM_CH-1:0] tick
);

    logic              cfg_ok;
    logic [NUM_CH-1:0] load;

    // Channel range matters when NUM_CH is not a power of two and cfg_ch can name a missing channel.
    always_comb begin
        cfg_ok = cfg_is_valid(CFG_MAX_W'(cfg_period), CFG_MAX_W'(cfg_high))
                 && (int'(cfg_ch) < NUM_CH);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = cfg_we && cfg_ok && (int'(cfg_ch) == i);

        clock_divider_ch #(
            .WIDTH          (WIDTH),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .enable     (ch_enable[i]),
            .load       (load[i]),
            .cfg_period (cfg_period),
            .cfg_high   (cfg_high),
            .pending    (cfg_pending[i]),
            .new_clock  (new_clock[i]),
            .tick       (tick[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

endmodule

// File: tb/tb_clock_divider_mc.sv
// tb/tb_clock_divider_mc.sv - self-checking bench for clock_divider_mc
module tb_clock_divider_mc;

    localparam int NUM_CH = 3;
    localparam int WIDTH  = 8;
    localparam int DEF_P  = 10;
    localparam int CH_W   = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] ch_enable = '0;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [WIDTH-1:0]  cfg_period = '0;
    logic [WIDTH-1:0]  cfg_high = '0;
    logic              cfg_err;
    logic [NUM_CH-1:0] cfg_pending;
    logic [NUM_CH-1:0] new_clock;
    logic [NUM_CH-1:0] tick;

    int n_checks = 0;
    int n_fail   = 0;

    clock_divider_mc #(
        .NUM_CH         (NUM_CH),
        .WIDTH          (WIDTH),
        .DEFAULT_PERIOD (DEF_P)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ch_enable   (ch_enable),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_err     (cfg_err),
        .cfg_pending (cfg_pending),
        .new_clock   (new_clock),
        .tick        (tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position within the current period (-1 when idle), active and pending config.
    int m_pos [NUM_CH];
    int m_p   [NUM_CH];
    int m_h   [NUM_CH];
    int m_pp  [NUM_CH];
    int m_ph  [NUM_CH];
    bit m_pend[NUM_CH];
    bit m_err;

    task automatic model_step();
        bit valid;
        bit boundary;
        valid = cfg_we && (int'(cfg_ch) < NUM_CH) && (int'(cfg_period) >= 2)
                && (int'(cfg_high) >= 1) && (int'(cfg_high) < int'(cfg_period));
        if (reset) begin
            m_err = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_pos[c]  = -1;
                m_p[c]    = DEF_P;
                m_h[c]    = DEF_P / 2;
                m_pend[c] = 1'b0;
            end
        end else begin
            m_err = cfg_we && !valid;
            for (int c = 0; c < NUM_CH; c++) begin
                boundary = (m_pos[c] < 0) || (ch_enable[c] && (m_pos[c] == m_p[c] - 1));
                if (ch_enable[c]) m_pos[c] = boundary ? 0 : m_pos[c] + 1;
                else              m_pos[c] = -1;
                if (m_pend[c] && boundary) begin
                    m_p[c]    = m_pp[c];
                    m_h[c]    = m_ph[c];
                    m_pend[c] = 1'b0;
                end
                if (valid && (int'(cfg_ch) == c)) begin
                    m_pp[c]   = int'(cfg_period);
                    m_ph[c]   = int'(cfg_high);
                    m_pend[c] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic [NUM_CH-1:0] e_clk;
        logic [NUM_CH-1:0] e_tick;
        logic [NUM_CH-1:0] e_pend;
        forever begin
            @(posedge clock);
            model_step();
            #1;
            for (int c = 0; c < NUM_CH; c++) begin
                e_tick[c] = (m_pos[c] == 0);
                e_clk[c]  = (m_pos[c] >= 0) && (m_pos[c] >= m_p[c] - m_h[c]);
                e_pend[c] = m_pend[c];
            end
            check("model_new_clock", 32'(new_clock), 32'(e_clk));
            check("model_tick", 32'(tick), 32'(e_tick));
            check("model_cfg_pending", 32'(cfg_pending), 32'(e_pend));
            check("model_cfg_err", 32'(cfg_err), 32'(m_err));
        end
    end

    task automatic cfg_write(input int ch, input int p, input int h);
        cfg_we     = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_period = WIDTH'(p);
        cfg_high   = WIDTH'(h);
        @(negedge clock);
        cfg_we = 1'b0;
    endtask

    task automatic wait_tick0();
        int n = 0;
        @(negedge clock);
        while (tick[0] !== 1'b1 && n < 30) begin
            @(negedge clock);
            n++;
        end
        check("wait_tick0_bound", 32'(tick[0]), 32'd1);
    endtask

    task automatic bad_write(input string name, input int ch, input int p, input int h);
        cfg_write(ch, p, h);
        check({name, "_err_pulse"}, 32'(cfg_err), 32'd1);
        check({name, "_no_pending"}, 32'(cfg_pending), 32'd0);
        @(negedge clock);
        check({name, "_err_one_cycle"}, 32'(cfg_err), 32'd0);
    endtask

    initial begin
        @(negedge clock);
        // Write during reset must be ignored.
        cfg_write(0, 4, 1);
        @(negedge clock);
        check("reset_new_clock", 32'(new_clock), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_pending", 32'(cfg_pending), 32'd0);
        check("reset_err", 32'(cfg_err), 32'd0);

        // Default period 10, high 5: tick at cycles 1, 11, 21; high in cycles 6..10.
        reset     = 1'b0;
        ch_enable = 3'b001;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clock);
            check("ch0_default_tick", 32'(tick[0]), 32'((k % 10) == 1));
            check("ch0_default_clk", 32'(new_clock[0]), 32'(((k - 1) % 10) >= 5));
            check("ch12_idle", 32'({tick[2:1], new_clock[2:1]}), 32'd0);
        end

        // Disabled channel takes a new config on the next edge.
        cfg_write(1, 4, 1);
        check("ch1_pending_set", 32'(cfg_pending[1]), 32'd1);
        @(negedge clock);
        check("ch1_pending_applied_idle", 32'(cfg_pending[1]), 32'd0);
        ch_enable[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("ch1_p4_tick", 32'(tick[1]), 32'((i % 4) == 0));
            check("ch1_p4_clk", 32'(new_clock[1]), 32'((i % 4) == 3));
        end

        // Running channel holds a mid-period write until the wrap.
        wait_tick0();
        repeat (2) @(negedge clock);
        cfg_write(0, 6, 3);
        check("ch0_pending_mid", 32'(cfg_pending[0]), 32'd1);
        wait_tick0();
        check("ch0_pending_cleared_at_wrap", 32'(cfg_pending[0]), 32'd0);
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) @(negedge clock);
            check("ch0_p6_tick", 32'(tick[0]), 32'((i % 6) == 0));
            check("ch0_p6_clk", 32'(new_clock[0]), 32'((i % 6) >= 3));
        end

        // Write on the wrap cycle: older pending (8/2) runs one period, then 4/2.
        wait_tick0();
        @(negedge clock);
        cfg_write(0, 8, 2);
        repeat (3) @(negedge clock);
        cfg_write(0, 4, 2);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clock);
            if (i < 8) begin
                check("wrapwr_old_tick", 32'(tick[0]), 32'(i == 0));
                check("wrapwr_old_clk", 32'(new_clock[0]), 32'(i >= 6));
                check("wrapwr_new_pending", 32'(cfg_pending[0]), 32'd1);
            end else begin
                check("wrapwr_new_tick", 32'(tick[0]), 32'(i == 8));
                check("wrapwr_new_clk", 32'(new_clock[0]), 32'((i - 8) >= 2));
                check("wrapwr_pending_done", 32'(cfg_pending[0]), 32'd0);
            end
        end

        // Invalid writes are dropped with a one-cycle error.
        bad_write("bad_p1", 0, 1, 1);
        bad_write("bad_h0", 0, 6, 0);
        bad_write("bad_h_eq_p", 0, 6, 6);
        bad_write("bad_ch", 3, 6, 3);

        // Smallest legal period: P=2, H=1 alternates every cycle.
        cfg_write(2, 2, 1);
        check("ch2_pending_set", 32'(cfg_pending[2]), 32'd1);
        @(negedge clock);
        check("ch2_pending_applied", 32'(cfg_pending[2]), 32'd0);
        ch_enable[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("ch2_p2_tick", 32'(tick[2]), 32'((i % 2) == 0));
            check("ch2_p2_clk", 32'(new_clock[2]), 32'((i % 2) == 1));
        end

        // Enable dropped with a write pending: outputs low, config lands one edge later.
        cfg_write(1, 5, 2);
        ch_enable[1] = 1'b0;
        @(negedge clock);
        check("ch1_drop_outputs", 32'({tick[1], new_clock[1]}), 32'd0);
        check("ch1_drop_pending_held", 32'(cfg_pending[1]), 32'd1);
        @(negedge clock);
        check("ch1_drop_pending_applied", 32'(cfg_pending[1]), 32'd0);

        // Reset mid-period with a pending write; a write during reset is ignored.
        wait_tick0();
        repeat (2) @(negedge clock);
        cfg_write(0, 5, 1);
        check("ch0_pending_before_reset", 32'(cfg_pending[0]), 32'd1);
        ch_enable  = 3'b001;
        reset      = 1'b1;
        cfg_we     = 1'b1;
        cfg_ch     = 2'd0;
        cfg_period = 8'd3;
        cfg_high   = 8'd1;
        @(negedge clock);
        reset  = 1'b0;
        cfg_we = 1'b0;
        check("rst_mid_outputs", 32'({new_clock, tick}), 32'd0);
        check("rst_mid_pending", 32'(cfg_pending), 32'd0);
        check("rst_mid_err", 32'(cfg_err), 32'd0);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clock);
            check("ch0_after_reset_tick", 32'(tick[0]), 32'((k % 10) == 1));
            check("ch0_after_reset_clk", 32'(new_clock[0]), 32'(((k - 1) % 10) >= 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
